// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - two-requester cache-line bus plus single-port memory bus for mem_arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [LINE_W-1:0] wdata0;
    logic              gnt0;
    logic              done0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [LINE_W-1:0] wdata1;
    logic              gnt1;
    logic              done1;

    logic [LINE_W-1:0] rdata;
    logic              busy;

    logic              mem_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_ack, mem_rdata,
        output gnt0, done0, gnt1, done1,
        output rdata, busy,
        output mem_valid, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_ack, mem_rdata,
        input  gnt0, done0, gnt1, done1,
        input  rdata, busy,
        input  mem_valid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of I-cache and D-cache line requests onto one memory port
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t state;
    logic   last_grant;
    logic   cur_port;
    logic   winner;

    // A lone requester always wins; on a tie the port that did not win last time goes.
    always_comb begin
        winner = bus.req1;
        if (bus.req0 && bus.req1) begin
            winner = ~last_grant;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            cur_port      <= 1'b0;
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.done0     <= 1'b0;
            bus.done1     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.rdata     <= {LINE_W{1'b0}};
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {ADDR_W{1'b0}};
            bus.mem_wdata <= {LINE_W{1'b0}};
        end else begin
            bus.gnt0  <= 1'b0;
            bus.gnt1  <= 1'b0;
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state         <= WAIT_MEM;
                        bus.busy      <= 1'b1;
                        bus.mem_valid <= 1'b1;
                        cur_port      <= winner;
                        last_grant    <= winner;
                        bus.gnt0      <= ~winner;
                        bus.gnt1      <= winner;
                        bus.mem_we    <= winner ? bus.we1    : bus.we0;
                        bus.mem_addr  <= winner ? bus.addr1  : bus.addr0;
                        bus.mem_wdata <= winner ? bus.wdata1 : bus.wdata0;
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_ack) begin
                        state         <= IDLE;
                        bus.busy      <= 1'b0;
                        bus.mem_valid <= 1'b0;
                        bus.done0     <= ~cur_port;
                        bus.done1     <= cur_port;
                        // Writes return no data, so the last read line stays visible.
                        if (!bus.mem_we) begin
                            bus.rdata <= bus.mem_rdata;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    localparam logic [127:0] LINE_A5 = {16{8'hA5}};

    mem_arbiter_if #(.ADDR_W(32), .LINE_W(128)) bus ();

    mem_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b exp 0", bus.busy); end
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid: got %0b exp 0", bus.mem_valid); end
        checks++; if (bus.rdata !== 128'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", bus.rdata); end
        checks++; if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1} !== 4'b0) begin errors++; $display("FAIL rst_pulses: got %b exp 0000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1}); end
        checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin errors++; $display("FAIL rst_mem_fields: got we=%0b addr=%h exp 0", bus.mem_we, bus.mem_addr); end
    endtask

    task automatic test_port0_read();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h100;
        tick();
        checks++; if ({bus.gnt0, bus.gnt1} !== 2'b10) begin errors++; $display("FAIL p0_gnt: got %b exp 10", {bus.gnt0, bus.gnt1}); end
        checks++; if (bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0 || bus.mem_valid !== 1'b1) begin errors++; $display("FAIL p0_mem_req: got addr=%h we=%0b valid=%0b exp 100/0/1", bus.mem_addr, bus.mem_we, bus.mem_valid); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL p0_busy: got %0b exp 1", bus.busy); end
        bus.req0 = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = LINE_A5;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if ({bus.done0, bus.done1, bus.gnt0, bus.gnt1} !== 4'b1000) begin errors++; $display("FAIL p0_done: got %b exp 1000", {bus.done0, bus.done1, bus.gnt0, bus.gnt1}); end
        checks++; if (bus.rdata !== LINE_A5) begin errors++; $display("FAIL p0_rdata: got %h exp %h", bus.rdata, LINE_A5); end
        checks++; if (bus.mem_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL p0_release: got valid=%0b busy=%0b exp 0/0", bus.mem_valid, bus.busy); end
        tick();
        checks++; if (bus.done0 !== 1'b0) begin errors++; $display("FAIL p0_done_width: got %0b exp 0", bus.done0); end
    endtask

    task automatic test_port1_write();
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h2000; bus.wdata1 = 128'h1234;
        tick();
        checks++; if ({bus.gnt0, bus.gnt1} !== 2'b01) begin errors++; $display("FAIL p1_gnt: got %b exp 01", {bus.gnt0, bus.gnt1}); end
        bus.req1 = 1'b0; bus.addr1 = 32'hFFFF; bus.wdata1 = '1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.mem_valid !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h2000 || bus.mem_wdata !== 128'h1234 || bus.done1 !== 1'b0) begin
                errors++;
                $display("FAIL p1_hold[%0d]: got valid=%0b we=%0b addr=%h wdata=%h done1=%0b exp 1/1/2000/1234/0", i, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.done1);
            end
            if (i == 4) bus.mem_ack = 1'b1;
            tick();
        end
        bus.mem_ack = 1'b0;
        checks++; if ({bus.done0, bus.done1} !== 2'b01) begin errors++; $display("FAIL p1_done: got %b exp 01", {bus.done0, bus.done1}); end
        checks++; if (bus.rdata !== LINE_A5) begin errors++; $display("FAIL p1_rdata_kept: got %h exp %h", bus.rdata, LINE_A5); end
        checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL p1_valid_drop: got %0b exp 0", bus.mem_valid); end
    endtask

    task automatic test_back_to_back();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h140;
        tick();
        checks++; if (bus.gnt0 !== 1'b1) begin errors++; $display("FAIL b2b_gnt_a: got %0b exp 1", bus.gnt0); end
        bus.mem_ack = 1'b1; bus.mem_rdata = 128'h11;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.done0 !== 1'b1 || bus.busy !== 1'b0 || bus.gnt0 !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got done0=%0b busy=%0b gnt0=%0b exp 1/0/0", bus.done0, bus.busy, bus.gnt0); end
        bus.addr0 = 32'h13F;
        tick();
        checks++; if (bus.gnt0 !== 1'b1 || bus.busy !== 1'b1 || bus.mem_addr !== 32'h13F) begin errors++; $display("FAIL b2b_gnt_b: got gnt0=%0b busy=%0b addr=%h exp 1/1/13f", bus.gnt0, bus.busy, bus.mem_addr); end
        bus.req0 = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 128'h22;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if (bus.done0 !== 1'b1 || bus.rdata !== 128'h22) begin errors++; $display("FAIL b2b_done_b: got done0=%0b rdata=%h exp 1/22", bus.done0, bus.rdata); end
    endtask

    task automatic test_idle_ack();
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 128'hDEAD;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if ({bus.done0, bus.done1, bus.busy} !== 3'b000) begin errors++; $display("FAIL idle_ack_pulses: got %b exp 000", {bus.done0, bus.done1, bus.busy}); end
        checks++; if (bus.rdata !== 128'h22) begin errors++; $display("FAIL idle_ack_rdata: got %h exp 22", bus.rdata); end
    endtask

    task automatic test_reset_mid_wait();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h300; bus.wdata0 = 128'h55;
        tick();
        bus.req0 = 1'b0;
        checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL rmw_pre_valid: got %0b exp 1", bus.mem_valid); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({bus.mem_valid, bus.busy, bus.mem_we, bus.gnt0, bus.done0} !== 5'b0) begin errors++; $display("FAIL rmw_async: got %b exp 00000", {bus.mem_valid, bus.busy, bus.mem_we, bus.gnt0, bus.done0}); end
        checks++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 128'h0 || bus.rdata !== 128'h0) begin errors++; $display("FAIL rmw_async_data: got addr=%h wdata=%h rdata=%h exp 0", bus.mem_addr, bus.mem_wdata, bus.rdata); end
        tick();
        reset = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 128'h77;
        tick();
        bus.mem_ack = 1'b0;
        checks++; if ({bus.done0, bus.done1, bus.busy, bus.mem_valid} !== 4'b0) begin errors++; $display("FAIL rmw_stale_ack: got %b exp 0000", {bus.done0, bus.done1, bus.busy, bus.mem_valid}); end
        checks++; if (bus.rdata !== 128'h0) begin errors++; $display("FAIL rmw_rdata: got %h exp 0", bus.rdata); end
    endtask

    task automatic test_round_robin();
        logic exp_port;
        idle_inputs();
        do_reset();
        bus.req0 = 1'b1; bus.addr0 = 32'h1000;
        bus.req1 = 1'b1; bus.addr1 = 32'h2000;
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_port = i[0];
            checks++;
            if ({bus.gnt0, bus.gnt1} !== {~exp_port, exp_port} || bus.mem_addr !== (exp_port ? 32'h2000 : 32'h1000)) begin
                errors++;
                $display("FAIL rr_gnt[%0d]: got gnt=%b addr=%h exp gnt=%b", i, {bus.gnt0, bus.gnt1}, bus.mem_addr, {~exp_port, exp_port});
            end
            bus.mem_ack = 1'b1; bus.mem_rdata = 128'(i + 1);
            tick();
            bus.mem_ack = 1'b0;
            checks++;
            if ({bus.done0, bus.done1, bus.gnt0, bus.gnt1} !== {~exp_port, exp_port, 2'b00} || bus.rdata !== 128'(i + 1)) begin
                errors++;
                $display("FAIL rr_done[%0d]: got done=%b gnt=%b rdata=%h exp done=%b rdata=%0d", i, {bus.done0, bus.done1}, {bus.gnt0, bus.gnt1}, bus.rdata, {~exp_port, exp_port}, i + 1);
            end
            if (i == 3) begin
                bus.req0 = 1'b0; bus.req1 = 1'b0;
            end
            tick();
        end
        checks++; if ({bus.busy, bus.gnt0, bus.gnt1} !== 3'b000) begin errors++; $display("FAIL rr_quiet: got %b exp 000", {bus.busy, bus.gnt0, bus.gnt1}); end
    endtask

    initial begin
        test_reset();
        test_port0_read();
        test_port1_write();
        test_back_to_back();
        test_idle_ack();
        test_reset_mid_wait();
        test_round_robin();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the byte address width of all address ports.
REQ-002 Parameter LINE_W, default 128, SHALL set the cache-line data width of all data ports.
REQ-003 Port clk, input, 1: SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: SHALL be the asynchronous, active-high reset.
REQ-005 Ports req0, we0 (input, 1) and addr0 (input, ADDR_W), wdata0 (input, LINE_W): SHALL be the port-0 (instruction cache) line request, write flag, line address and write data.
REQ-006 Ports gnt0, done0 (output, 1): SHALL be the port-0 accept pulse and completion pulse.
REQ-007 Ports req1, we1, addr1, wdata1, gnt1, done1: SHALL be the port-1 (data cache) equivalents of REQ-005/006.
REQ-008 Port rdata, output, LINE_W: SHALL be the read line returned to the completing port.
REQ-009 Ports mem_valid, mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, LINE_W): SHALL be the request to the single-port main memory.
REQ-010 Ports mem_ack (input, 1), mem_rdata (input, LINE_W): SHALL be the memory completion strobe and read data.
REQ-011 Port busy, output, 1: SHALL be high whenever state is not IDLE.

Function
REQ-012 States SHALL be IDLE and WAIT_MEM only.
REQ-013 In IDLE, at a rising edge with req0 or req1 high, the arbiter SHALL accept exactly one request, latch its we/addr/wdata and port id, and enter WAIT_MEM.
REQ-014 With one request pending, that port SHALL win; with both pending, the port not equal to last_grant SHALL win (round-robin).
REQ-015 last_grant SHALL update to the winner on every acceptance.
REQ-016 gntN SHALL be high for exactly the one cycle following the accepting edge, and never for the losing port.
REQ-017 Requesters SHALL hold req and the request fields stable until gnt; req sampled outside IDLE SHALL be ignored.
REQ-018 In WAIT_MEM, mem_valid SHALL be 1, with mem_we/mem_addr/mem_wdata driven from the latched request, held constant until mem_ack.
REQ-019 On a rising edge in WAIT_MEM with mem_ack=1, the arbiter SHALL return to IDLE, pulse doneN of the latched port for exactly one cycle, and drop mem_valid in that same following cycle.
REQ-020 For a read completion, rdata SHALL load mem_rdata at the ack edge and hold until the next read completion; write completions SHALL leave rdata unchanged.
REQ-021 mem_ack in IDLE SHALL be ignored.
REQ-022 A new acceptance SHALL require an IDLE-state edge; minimum req-to-done latency SHALL be 2 edges (accept, ack), so back-to-back transactions are separated by at least one IDLE cycle.
REQ-023 With both ports requesting continuously, grants SHALL strictly alternate; no port waits more than one foreign transaction.
REQ-024 mem_addr SHALL be passed unmodified (no alignment or masking).

Reset
REQ-025 Asserting reset SHALL immediately force IDLE, last_grant=1, rdata=0, and gnt0/gnt1/done0/done1/mem_valid/mem_we/busy=0, mem_addr=0, mem_wdata=0.
REQ-026 Reset during WAIT_MEM SHALL abandon the transaction with no done pulse; a later stale mem_ack SHALL be ignored.
REQ-027 First tie after reset SHALL be won by port 0.

Verification
REQ-028 Port-0 read only: req0=1, addr0=0x100, ack one cycle later with mem_rdata=0xA5..A5 -> gnt0 one cycle, mem_addr=0x100, mem_we=0, done0 one cycle, rdata=0xA5..A5, gnt1/done1 stay 0.
REQ-029 Simultaneous req0/req1 after reset, held after each done -> grant order 0,1,0,1; each done matches its own gnt.
REQ-030 Port-1 write: we1=1, addr1=0x2000, wdata1=0x1234, ack after 5 cycles -> mem_valid high 5 cycles with stable fields, done1 one cycle, rdata unchanged.
REQ-031 Reset asserted mid-WAIT_MEM, then mem_ack pulsed -> outputs zero asynchronously, no done pulse, state stays IDLE.
REQ-032 mem_ack pulsed while IDLE with no requests -> no done, busy=0, rdata unchanged.
